// File: rtl/maxpool_vertical_stage.sv
// Vertical stage of a 2x2 max-pool: pairs vertically adjacent rows of horizontal maxima.
// Latency: 1 cycle from the accepting edge of the completing row to out_valid.
// Backpressure: in_ready = !out_valid || out_ready; output is held stable until taken.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, stride_mode  frame start pulse; stride select (0 = stride 2, 1 = stride 1) loaded on start
//   in_valid/in_ready   input row handshake, data_in = NUM_MODULES lanes of DATA_WIDTH
//   out_valid/out_ready output row handshake, data_out = pooled row
module maxpool_vertical_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MODULES = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              stride_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0] data_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*NUM_MODULES-1:0] data_out
);

  localparam int ROW_W = DATA_WIDTH * NUM_MODULES;
  localparam int HALF  = NUM_MODULES / 2;

  logic [ROW_W-1:0] row_buf;
  logic             buf_valid;
  logic             parity;
  logic             stride1;

  logic [ROW_W-1:0] vmax;
  logic [ROW_W-1:0] compact;
  logic             accept;
  logic             eff_parity;
  logic             eff_buf_valid;
  logic             eff_stride1;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // start takes effect before a row accepted in the same cycle, so that row
  // is treated as the first row of the new frame.
  assign eff_parity    = start ? 1'b0 : parity;
  assign eff_buf_valid = start ? 1'b0 : buf_valid;
  assign eff_stride1   = start ? stride_mode : stride1;

  // Lane-wise signed max of buffered row and incoming row, plus the stride-2
  // compaction that keeps every even lane and zero-fills the upper half.
  always_comb begin
    vmax    = '0;
    compact = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      if ($signed(row_buf[i*DATA_WIDTH +: DATA_WIDTH]) > $signed(data_in[i*DATA_WIDTH +: DATA_WIDTH]))
        vmax[i*DATA_WIDTH +: DATA_WIDTH] = row_buf[i*DATA_WIDTH +: DATA_WIDTH];
      else
        vmax[i*DATA_WIDTH +: DATA_WIDTH] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int k = 0; k < HALF; k++) begin
      compact[k*DATA_WIDTH +: DATA_WIDTH] = vmax[2*k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      row_buf   <= '0;
      buf_valid <= 1'b0;
      parity    <= 1'b0;
      stride1   <= 1'b0;
    end else begin
      if (start) begin
        parity    <= 1'b0;
        buf_valid <= 1'b0;
        stride1   <= stride_mode;
      end

      // Drop valid after a transfer; a new result below overrides this.
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (accept) begin
        if (!eff_stride1) begin
          if (!eff_parity) begin
            row_buf <= data_in;
            parity  <= 1'b1;
          end else begin
            data_out  <= compact;
            out_valid <= 1'b1;
            parity    <= 1'b0;
          end
        end else begin
          // Sliding window: every row becomes the partner of the next one.
          row_buf   <= data_in;
          buf_valid <= 1'b1;
          if (eff_buf_valid) begin
            data_out  <= vmax;
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
